// File: rtl/conv_window_feeder_if.sv
// Window output bus of the convolution feeder.
// Carries one packed image window plus the packed filter, the valid/ready
// handshake and the (row, col) position of the window.
//   master : the feeder (drives window, filter, valid, row, col; samples ready)
//   slave  : the conv unit (samples everything; drives ready)
interface conv_window_feeder_if #(
    parameter int unsigned N   = 8,
    parameter int unsigned FIL = 3
);
    localparam int unsigned OUT = FIL * FIL * N;

    logic           win_valid;
    logic           win_ready;
    logic [OUT-1:0] i_out;
    logic [OUT-1:0] f_out;
    logic [4:0]     win_row;
    logic [4:0]     win_col;

    modport master (
        output win_valid,
        input  win_ready,
        output i_out,
        output f_out,
        output win_row,
        output win_col
    );

    modport slave (
        input  win_valid,
        output win_ready,
        input  i_out,
        input  f_out,
        input  win_row,
        input  win_col
    );
endinterface

// File: rtl/conv_window_feeder.sv
// Producer side of the 3x3 convolution datapath.
// Loads the filter once per frame, then sweeps every valid window position of an
// IMG x IMG image, presenting one packed window per valid/ready handshake. Within
// a row only the new rightmost column is fetched; the other columns are shifted.
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   start_i           : begin a frame (sampled in idle only)
//   base_addr_i       : image base address, latched on start
//   img_addr_o        : image memory read address (data returns one cycle later)
//   img_rdata_i       : image memory read data
//   fil_addr_o        : filter memory read address (data returns one cycle later)
//   fil_rdata_i       : filter memory read data
//   busy_o            : high from start acceptance until end of frame
//   done_o            : one-cycle pulse at end of frame
//   win_io            : window bus (packed window/filter, handshake, row/col)
// Element (i,j) of a packed window sits at bits [(FIL*i+j)*N +: N].
module conv_window_feeder #(
    parameter int unsigned N    = 8,
    parameter int unsigned M_AW = 13,
    parameter int unsigned F_AW = 4,
    parameter int unsigned FIL  = 3,
    parameter int unsigned IMG  = 28,
    parameter int unsigned OUT  = FIL * FIL * N
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [M_AW-1:0]        base_addr_i,
    output logic [M_AW-1:0]        img_addr_o,
    input  logic [N-1:0]           img_rdata_i,
    output logic [F_AW-1:0]        fil_addr_o,
    input  logic [N-1:0]           fil_rdata_i,
    output logic                   busy_o,
    output logic                   done_o,
    conv_window_feeder_if.master   win_io
);

    localparam int unsigned NE = FIL * FIL;
    localparam int unsigned CW = $clog2(NE + 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoadF   = 3'd1;
    localparam logic [2:0] StLoadW   = 3'd2;
    localparam logic [2:0] StPresent = 3'd3;
    localparam logic [2:0] StFin     = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M_AW-1:0] base_q, base_d;
    logic [4:0]      r_q, r_d;
    logic [4:0]      c_q, c_d;
    logic [OUT-1:0]  i_win_q, i_win_d;
    logic [OUT-1:0]  f_win_q, f_win_d;
    logic [M_AW-1:0] img_addr_q, img_addr_d;
    logic [F_AW-1:0] fil_addr_q, fil_addr_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Address of window element (i,j) for the window at (r,c); wraps at M_AW bits.
    function automatic logic [M_AW-1:0] pix_addr(input logic [M_AW-1:0] base,
                                                 input logic [4:0]      r,
                                                 input logic [4:0]      c,
                                                 input int unsigned     i,
                                                 input int unsigned     j);
        int unsigned off;
        off = (32'(r) + i) * IMG + 32'(c) + j;
        return base + M_AW'(off);
    endfunction

    always_comb begin
        int unsigned cur;
        int unsigned nxt;
        int unsigned prv;

        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        r_d        = r_q;
        c_d        = c_q;
        i_win_d    = i_win_q;
        f_win_d    = f_win_q;
        img_addr_d = img_addr_q;
        fil_addr_d = fil_addr_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // Cycle cnt issues address cnt and captures the data of address cnt-1.
        cur = 32'(cnt_q);
        nxt = cur + 1;
        prv = cur - 1;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    base_d     = base_addr_i;
                    busy_d     = 1'b1;
                    r_d        = '0;
                    c_d        = '0;
                    cnt_d      = '0;
                    fil_addr_d = '0;
                    state_d    = StLoadF;
                end
            end

            StLoadF: begin
                if (cur != 0) begin
                    f_win_d[prv*N +: N] = fil_rdata_i;
                end
                if (nxt < NE) begin
                    fil_addr_d = F_AW'(nxt);
                end
                if (cur == NE) begin
                    cnt_d      = '0;
                    img_addr_d = pix_addr(base_q, r_q, c_q, 0, 0);
                    state_d    = StLoadW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StLoadW: begin
                if (c_q == '0) begin
                    // Full load, i-major then j.
                    if (cur != 0) begin
                        i_win_d[prv*N +: N] = img_rdata_i;
                    end
                    if (nxt < NE) begin
                        img_addr_d = pix_addr(base_q, r_q, c_q, nxt / FIL, nxt % FIL);
                    end
                    if (cur == NE) begin
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        state_d = StPresent;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Slide: window already shifted, fill the rightmost column.
                    if (cur != 0) begin
                        i_win_d[(prv * FIL + FIL - 1) * N +: N] = img_rdata_i;
                    end
                    if (nxt < FIL) begin
                        img_addr_d = pix_addr(base_q, r_q, c_q, nxt, FIL - 1);
                    end
                    if (cur == FIL) begin
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        state_d = StPresent;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            StPresent: begin
                if (valid_q && win_io.win_ready) begin
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    if (32'(c_q) < IMG - FIL) begin
                        c_d = c_q + 5'd1;
                        for (int unsigned i = 0; i < FIL; i++) begin
                            for (int unsigned j = 0; j < FIL - 1; j++) begin
                                i_win_d[(i * FIL + j) * N +: N] =
                                    i_win_q[(i * FIL + j + 1) * N +: N];
                            end
                        end
                        img_addr_d = pix_addr(base_q, r_q, c_q + 5'd1, 0, FIL - 1);
                        state_d    = StLoadW;
                    end else if (32'(r_q) < IMG - FIL) begin
                        c_d        = '0;
                        r_d        = r_q + 5'd1;
                        img_addr_d = pix_addr(base_q, r_q + 5'd1, 5'd0, 0, 0);
                        state_d    = StLoadW;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StFin;
                    end
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            base_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            i_win_q    <= '0;
            f_win_q    <= '0;
            img_addr_q <= '0;
            fil_addr_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            r_q        <= r_d;
            c_q        <= c_d;
            i_win_q    <= i_win_d;
            f_win_q    <= f_win_d;
            img_addr_q <= img_addr_d;
            fil_addr_q <= fil_addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign img_addr_o       = img_addr_q;
    assign fil_addr_o       = fil_addr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign win_io.win_valid = valid_q;
    assign win_io.i_out     = i_win_q;
    assign win_io.f_out     = f_win_q;
    assign win_io.win_row   = r_q;
    assign win_io.win_col   = c_q;

endmodule
